// File: rtl/bus_router_pkg.sv
// Shared configuration for the bus router: slave count, address map and FSM states.
package configure;

  localparam int NUM_SLAVES = 4;

  // Regions are [base, top). Slave 3 has an empty region so it is never selected.
  localparam logic [NUM_SLAVES-1:0][31:0] BASE_ADDR = {
    32'hFFFF_FFFF, 32'h1000_0000, 32'h0200_0000, 32'h0000_0000
  };
  localparam logic [NUM_SLAVES-1:0][31:0] TOP_ADDR = {
    32'hFFFF_FFFF, 32'h1000_1000, 32'h0201_0000, 32'h0010_0000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } router_state_t;

  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/bus_router_if.sv
// Master-side request/response bus plus the per-slave fan-out, bundled for the router.
interface bus_router_if #(
  parameter int NUM_SLAVES = configure::NUM_SLAVES
);

  // A request is a single-cycle memory_valid strobe; the router answers with a
  // single-cycle memory_ready (memory_error marks a decode or timeout failure).
  // Slaves see the same strobe on slave_valid and complete with slave_ready.
  logic                            memory_valid;
  logic                            memory_instr;
  logic [31:0]                     memory_addr;
  logic [31:0]                     memory_wdata;
  logic [3:0]                      memory_wstrb;
  logic [31:0]                     memory_rdata;
  logic                            memory_ready;
  logic                            memory_error;

  logic [NUM_SLAVES-1:0]           slave_valid;
  logic [NUM_SLAVES-1:0]           slave_instr;
  logic [NUM_SLAVES-1:0][31:0]     slave_addr;
  logic [NUM_SLAVES-1:0][31:0]     slave_wdata;
  logic [NUM_SLAVES-1:0][3:0]      slave_wstrb;
  logic [NUM_SLAVES-1:0][31:0]     slave_rdata;
  logic [NUM_SLAVES-1:0]           slave_ready;

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output memory_rdata, memory_ready, memory_error,
    output slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
    input  slave_rdata, slave_ready
  );

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  memory_rdata, memory_ready, memory_error,
    input  slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
    output slave_rdata, slave_ready
  );

endinterface

// File: rtl/bus_router_timer.sv
// Wait-cycle counter for the router; expired fires in the cycle the count would reach TIMEOUT.
module bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/bus_router.sv
// Address-decoding router: forwards one master request to a slave and returns its response.
module bus_router
  import configure::*;
#(
  parameter int                          NUM_SLAVES = configure::NUM_SLAVES,
  parameter int                          TIMEOUT    = 255,
  parameter logic [NUM_SLAVES-1:0][31:0] BASE_ADDR  = configure::BASE_ADDR,
  parameter logic [NUM_SLAVES-1:0][31:0] TOP_ADDR   = configure::TOP_ADDR
) (
  input  logic          clock,
  input  logic          reset,
  bus_router_if.slave   bus,
  output router_state_t fsm_state
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  router_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_any;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             accept;
  logic             req;
  logic             timer_clear;
  logic             timer_enable;
  logic             expired;
  logic             rsp_ready;
  logic             rsp_error;
  logic [31:0]      rsp_rdata;

  // Scanning downward lets the lowest matching index win on overlap.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (in_region(bus.memory_addr, BASE_ADDR[i], TOP_ADDR[i])) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ready    = bus.slave_ready[idx_q];
  assign sel_rdata    = bus.slave_rdata[idx_q];
  assign accept       = (state_q == IDLE) || ((state_q == WAIT) && sel_ready);
  assign req          = reset && bus.memory_valid && accept;
  assign timer_enable = (state_q == WAIT) && !sel_ready;

  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_clear = 1'b0;
    rsp_ready   = 1'b0;
    rsp_error   = 1'b0;
    rsp_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d = hit_idx;
          if (!hit_any) begin
            state_d = ERR;
          end else if (bus.slave_ready[hit_idx]) begin
            rsp_ready = 1'b1;
            rsp_rdata = bus.slave_rdata[hit_idx];
          end else begin
            state_d     = WAIT;
            timer_clear = 1'b1;
          end
        end
      end
      WAIT: begin
        if (sel_ready) begin
          rsp_ready = 1'b1;
          rsp_rdata = sel_rdata;
          state_d   = IDLE;
          // A request landing on the completion cycle chains straight into the next access.
          if (req) begin
            idx_d = hit_idx;
            if (!hit_any) begin
              state_d = ERR;
            end else begin
              state_d     = WAIT;
              timer_clear = 1'b1;
            end
          end
        end else if (expired) begin
          rsp_ready = 1'b1;
          rsp_error = 1'b1;
          state_d   = IDLE;
        end
      end
      ERR: begin
        rsp_ready = 1'b1;
        rsp_error = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      bus.slave_valid[i] = req && hit_any && (hit_idx == IDX_W'(i));
      bus.slave_instr[i] = bus.memory_instr;
      bus.slave_addr[i]  = bus.memory_addr - BASE_ADDR[i];
      bus.slave_wdata[i] = bus.memory_wdata;
      bus.slave_wstrb[i] = bus.memory_wstrb;
    end
  end

  assign bus.memory_ready = reset && rsp_ready;
  assign bus.memory_error = reset && rsp_error;
  assign bus.memory_rdata = reset ? rsp_rdata : '0;
  assign fsm_state        = state_q;

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: directed scenarios plus randomized traffic vs. a map model.
module tb_bus_router;
  import configure::*;

  localparam int NS        = 4;
  localparam int TIMEOUT_P = 4;
  localparam logic [31:0] REF_BASE [3] = '{32'h0000_0000, 32'h0200_0000, 32'h1000_0000};
  localparam logic [31:0] REF_TOP  [3] = '{32'h0010_0000, 32'h0201_0000, 32'h1000_1000};

  logic          clock;
  logic          reset;
  router_state_t fsm_state;
  int            n_cmp;
  int            n_fail;
  logic [40:0]   exp_q[$];

  bus_router_if #(.NUM_SLAVES(NS)) bus ();

  bus_router #(
    .NUM_SLAVES (NS),
    .TIMEOUT    (TIMEOUT_P)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference decode straight from the bench address map; -1 means unmapped.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++) begin
      if (a >= REF_BASE[i] && a < REF_TOP[i]) return i;
    end
    return -1;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    bus.memory_addr  = '0;
    bus.memory_wdata = '0;
    bus.memory_wstrb = '0;
    bus.slave_ready  = '0;
    bus.slave_rdata  = '0;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic instr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.memory_valid = 1'b1;
    bus.memory_instr = instr;
    bus.memory_addr  = addr;
    bus.memory_wdata = wdata;
    bus.memory_wstrb = wstrb;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_req(32'h0000_0010, 1'b0, 32'h1234_5678, 4'hF);
    bus.slave_ready = '1;
    bus.slave_rdata = {4{32'hA5A5_A5A5}};
    @(posedge clock);
    @(negedge clock);
    n_cmp++; if (bus.memory_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.memory_ready); end
    n_cmp++; if (bus.memory_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", bus.memory_error); end
    n_cmp++; if (bus.memory_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.memory_rdata); end
    n_cmp++; if (bus.slave_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_slave_valid: got %b want 0000", bus.slave_valid); end
    n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
    step();
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_read();
    step();
    drive_req(32'h0000_0010, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if (bus.slave_valid !== 4'b0001) begin n_fail++; $display("FAIL read_slave_valid: got %b want 0001", bus.slave_valid); end
    n_cmp++; if (bus.slave_addr[0] !== 32'h10) begin n_fail++; $display("FAIL read_slave_addr: got %h want 10", bus.slave_addr[0]); end
    n_cmp++; if (bus.memory_ready !== 1'b0) begin n_fail++; $display("FAIL read_early_ready: got %b want 0", bus.memory_ready); end
    step();
    bus.memory_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.memory_ready !== 1'b0 || fsm_state !== WAIT) begin n_fail++; $display("FAIL read_wait: ready %b state %0d want 0/WAIT", bus.memory_ready, fsm_state); end
    step();
    bus.slave_ready[0] = 1'b1;
    bus.slave_rdata[0] = 32'hDEAD_BEEF;
    @(negedge clock);
    n_cmp++; if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL read_rsp: got r%b e%b %h want r1 e0 deadbeef", bus.memory_ready, bus.memory_error, bus.memory_rdata); end
    step();
    idle_inputs();
    @(negedge clock);
    n_cmp++; if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== 34'h0 || fsm_state !== IDLE) begin
      n_fail++; $display("FAIL idle_quiet: got r%b e%b %h state %0d want zeros/IDLE", bus.memory_ready, bus.memory_error, bus.memory_rdata, fsm_state); end
  endtask

  task automatic test_write_zero_wait();
    logic [31:0] wd;
    wd = $urandom;
    step();
    drive_req(32'h0200_0008, 1'b1, wd, 4'b0011);
    bus.slave_ready[1] = 1'b1;
    bus.slave_rdata[1] = 32'h0BAD_F00D;
    @(negedge clock);
    n_cmp++; if (bus.slave_valid !== 4'b0010) begin n_fail++; $display("FAIL zw_slave_valid: got %b want 0010", bus.slave_valid); end
    n_cmp++; if (bus.slave_addr[1] !== 32'h8) begin n_fail++; $display("FAIL zw_slave_addr: got %h want 8", bus.slave_addr[1]); end
    n_cmp++; if (bus.slave_wstrb[2] !== 4'b0011 || bus.slave_wdata[3] !== wd || bus.slave_instr !== 4'hF) begin
      n_fail++; $display("FAIL zw_broadcast: strb %b data %h instr %b want 0011 %h 1111", bus.slave_wstrb[2], bus.slave_wdata[3], bus.slave_instr, wd); end
    n_cmp++; if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL zw_rsp: got r%b e%b %h want r1 e0 0badf00d", bus.memory_ready, bus.memory_error, bus.memory_rdata); end
    step();
    idle_inputs();
    @(negedge clock);
    n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL zw_state: got %0d want IDLE", fsm_state); end
  endtask

  task automatic test_unmapped();
    step();
    drive_req(32'h4000_0000, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if (bus.slave_valid !== 4'b0000 || bus.memory_ready !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_fwd: valid %b ready %b want 0000 0", bus.slave_valid, bus.memory_ready); end
    step();
    idle_inputs();
    bus.slave_ready = 4'b0111;
    bus.slave_rdata = {4{32'h7777_7777}};
    @(negedge clock);
    n_cmp++; if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b11, 32'h0}) begin
      n_fail++; $display("FAIL unmapped_err: got r%b e%b %h want r1 e1 0", bus.memory_ready, bus.memory_error, bus.memory_rdata); end
    step();
    idle_inputs();
    @(negedge clock);
    n_cmp++; if (bus.memory_ready !== 1'b0 || fsm_state !== IDLE) begin
      n_fail++; $display("FAIL err_one_cycle: ready %b state %0d want 0/IDLE", bus.memory_ready, fsm_state); end
  endtask

  task automatic test_timeout();
    step();
    drive_req(32'h1000_0000, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if (bus.slave_valid !== 4'b0100) begin n_fail++; $display("FAIL to_slave_valid: got %b want 0100", bus.slave_valid); end
    for (int c = 1; c <= TIMEOUT_P; c++) begin
      step();
      bus.memory_valid = 1'b0;
      bus.slave_ready  = 4'b1011;
      @(negedge clock);
      if (c < TIMEOUT_P) begin
        n_cmp++; if (bus.memory_ready !== 1'b0) begin n_fail++; $display("FAIL to_early cycle %0d: ready %b want 0", c, bus.memory_ready); end
      end else begin
        n_cmp++; if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b11, 32'h0}) begin
          n_fail++; $display("FAIL to_expire: got r%b e%b %h want r1 e1 0", bus.memory_ready, bus.memory_error, bus.memory_rdata); end
      end
    end
    step();
    idle_inputs();
    bus.slave_ready[2] = 1'b1;
    bus.slave_rdata[2] = 32'hCAFE_0002;
    @(negedge clock);
    n_cmp++; if (bus.memory_ready !== 1'b0) begin n_fail++; $display("FAIL to_late_ready: ready %b want 0", bus.memory_ready); end
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    step();
    drive_req(32'h0000_0100, 1'b0, 32'h0, 4'h0);
    step();
    bus.memory_valid = 1'b0;
    step();
    bus.slave_ready[0] = 1'b1;
    bus.slave_rdata[0] = 32'h1111_0000;
    drive_req(32'h1000_0004, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if ({bus.memory_ready, bus.memory_rdata} !== {1'b1, 32'h1111_0000}) begin
      n_fail++; $display("FAIL b2b_first: got r%b %h want r1 11110000", bus.memory_ready, bus.memory_rdata); end
    n_cmp++; if (bus.slave_valid !== 4'b0100 || bus.slave_addr[2] !== 32'h4) begin
      n_fail++; $display("FAIL b2b_forward: valid %b addr %h want 0100 4", bus.slave_valid, bus.slave_addr[2]); end
    step();
    bus.memory_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.memory_ready !== 1'b0 || fsm_state !== WAIT) begin
      n_fail++; $display("FAIL b2b_other_ready: ready %b state %0d want 0/WAIT", bus.memory_ready, fsm_state); end
    step();
    bus.slave_ready = 4'b0100;
    bus.slave_rdata[2] = 32'h2222_0002;
    @(negedge clock);
    n_cmp++; if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b10, 32'h2222_0002}) begin
      n_fail++; $display("FAIL b2b_second: got r%b e%b %h want r1 e0 22220002", bus.memory_ready, bus.memory_error, bus.memory_rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_dropped();
    step();
    drive_req(32'h0200_0000, 1'b0, 32'h0, 4'h0);
    step();
    drive_req(32'h0000_0020, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if (bus.slave_valid !== 4'b0000) begin n_fail++; $display("FAIL drop_valid: got %b want 0000", bus.slave_valid); end
    step();
    idle_inputs();
    @(negedge clock);
    n_cmp++; if (fsm_state !== WAIT) begin n_fail++; $display("FAIL drop_state: got %0d want WAIT", fsm_state); end
    step();
    bus.slave_ready[1] = 1'b1;
    bus.slave_rdata[1] = 32'h0000_00D1;
    @(negedge clock);
    n_cmp++; if ({bus.memory_ready, bus.memory_rdata} !== {1'b1, 32'h0000_00D1}) begin
      n_fail++; $display("FAIL drop_complete: got r%b %h want r1 000000d1", bus.memory_ready, bus.memory_rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    step();
    drive_req(32'h0200_0040, 1'b0, 32'h0, 4'h0);
    step();
    bus.memory_valid = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.memory_ready !== 1'b0 || bus.memory_error !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_rsp: ready %b error %b want 0 0", bus.memory_ready, bus.memory_error); end
    step();
    reset = 1'b1;
    bus.slave_ready[1] = 1'b1;
    bus.slave_rdata[1] = 32'hFACE_0001;
    @(negedge clock);
    n_cmp++; if (bus.memory_ready !== 1'b0 || fsm_state !== IDLE) begin
      n_fail++; $display("FAIL rst_mid_late: ready %b state %0d want 0/IDLE", bus.memory_ready, fsm_state); end
    step();
    idle_inputs();
    drive_req(32'h0000_0040, 1'b0, 32'h0, 4'h0);
    bus.slave_ready[0] = 1'b1;
    bus.slave_rdata[0] = 32'h0000_0A0A;
    @(negedge clock);
    n_cmp++; if (bus.slave_valid !== 4'b0001 || {bus.memory_ready, bus.memory_rdata} !== {1'b1, 32'h0000_0A0A}) begin
      n_fail++; $display("FAIL rst_mid_next: valid %b r%b %h want 0001 r1 00000a0a", bus.slave_valid, bus.memory_ready, bus.memory_rdata); end
    step();
    idle_inputs();
  endtask

  // One randomized access; the model predicts response cycle, error and data.
  task automatic run_txn(input logic [31:0] addr, input int lat, input logic [31:0] data);
    int          idx;
    bit          done;
    logic [40:0] exp_v;
    logic [40:0] got_v;
    logic [3:0]  m;
    logic [3:0]  exp_valid;
    logic [31:0] wd;
    logic        ins;
    idx = ref_decode(addr);
    if (idx < 0)              exp_q.push_back({8'd1, 1'b1, 32'h0});
    else if (lat <= TIMEOUT_P) exp_q.push_back({8'(lat), 1'b0, data});
    else                      exp_q.push_back({8'(TIMEOUT_P), 1'b1, 32'h0});
    exp_valid = (idx < 0) ? 4'b0000 : 4'(1 << idx);
    wd   = $urandom;
    ins  = 1'($urandom_range(0, 1));
    done = 0;
    for (int c = 0; c <= TIMEOUT_P + 1 && !done; c++) begin
      step();
      if (c == 0) drive_req(addr, ins, wd, 4'($urandom_range(0, 15)));
      else        bus.memory_valid = 1'b0;
      m = 4'($urandom_range(0, 15));
      if (idx >= 0) m[idx] = (c == lat);
      bus.slave_ready = m;
      for (int i = 0; i < NS; i++) bus.slave_rdata[i] = (i == idx) ? data : $urandom;
      @(negedge clock);
      if (c == 0) begin
        n_cmp++; if (bus.slave_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid @%h: got %b want %b", addr, bus.slave_valid, exp_valid); end
        for (int i = 0; i < 3; i++) begin
          n_cmp++; if (bus.slave_addr[i] !== addr - REF_BASE[i]) begin
            n_fail++; $display("FAIL rand_addr%0d @%h: got %h want %h", i, addr, bus.slave_addr[i], addr - REF_BASE[i]); end
        end
        n_cmp++; if (bus.slave_wdata[3] !== wd || bus.slave_instr !== {4{ins}}) begin
          n_fail++; $display("FAIL rand_bcast: data %h instr %b want %h %b", bus.slave_wdata[3], bus.slave_instr, wd, {4{ins}}); end
      end
      if (bus.memory_ready) begin
        done  = 1;
        got_v = {8'(c), bus.memory_error, bus.memory_rdata};
        exp_v = exp_q.pop_front();
        n_cmp++; if (got_v !== exp_v) begin
          n_fail++; $display("FAIL rand_rsp @%h lat %0d: got cyc %0d e%b %h want cyc %0d e%b %h",
                             addr, lat, got_v[40:33], got_v[32], got_v[31:0], exp_v[40:33], exp_v[32], exp_v[31:0]); end
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      exp_v = exp_q.pop_front();
      $display("FAIL rand_no_rsp @%h lat %0d: got no ready want cyc %0d", addr, lat, exp_v[40:33]);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          r;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 4);
      if (r < 3) begin
        case ($urandom_range(0, 2))
          0:       a = REF_BASE[r];
          1:       a = REF_TOP[r] - 32'd1;
          default: a = REF_BASE[r] + ($urandom % (REF_TOP[r] - REF_BASE[r]));
        endcase
      end else if (r == 3) begin
        a = REF_TOP[$urandom_range(0, 2)];
      end else begin
        a = $urandom;
      end
      run_txn(a, $urandom_range(0, TIMEOUT_P + 2), $urandom);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_read();
    test_write_zero_wait();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_dropped();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
